// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade driver.
// Holds brightness limits, PWM period end and prescaler width.
package led_pkg;

    localparam int PRESC_W = 20;

    typedef logic [3:0]         level_t;
    typedef logic [PRESC_W-1:0] presc_t;

    localparam level_t LEVEL_MAX = 4'd15;
    localparam level_t PWM_LAST  = 4'd14;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level with decay, and the PWM comparator.
// Ports: clk, rst_ni (sync, active-low), req_i, tick_i, pwm_i, led_o.
module led_fade_channel
    import led_pkg::*;
(
    input  logic   clk,
    input  logic   rst_ni,
    input  logic   req_i,
    input  logic   tick_i,
    input  level_t pwm_i,
    output logic   led_o
);

    level_t level_q;
    level_t level_d;
    logic   led_q;

    // A request always wins over a decay step in the same cycle.
    always_comb begin
        level_d = level_q;
        if (req_i) begin
            level_d = LEVEL_MAX;
        end else if (tick_i && (level_q != '0)) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= (level_q > pwm_i);
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_fade_driver.sv
// Eight-channel LED fader: requests light an LED fully, then it decays.
// Ports: clk, NOTRESET (sync, active-low), PATTERN[7:0], LED7..LED0.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int unsigned DECAY_DIV = 800000
) (
    input  logic       clk,
    input  logic       NOTRESET,
    input  logic [7:0] PATTERN,
    output logic       LED7,
    output logic       LED6,
    output logic       LED5,
    output logic       LED4,
    output logic       LED3,
    output logic       LED2,
    output logic       LED1,
    output logic       LED0
);

    localparam presc_t PRESC_LAST = presc_t'(DECAY_DIV - 1);

    logic [7:0] pat_q;
    presc_t     presc_q;
    presc_t     presc_d;
    level_t     pwm_q;
    level_t     pwm_d;
    logic       tick;
    logic [7:0] led_vec;

    // With DECAY_DIV=1 the prescaler sits at 0 and ticks every cycle.
    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (tick) begin
            presc_d = '0;
        end
        pwm_d = pwm_q + 1'b1;
        if (pwm_q == PWM_LAST) begin
            pwm_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!NOTRESET) begin
            pat_q   <= '0;
            presc_q <= '0;
            pwm_q   <= '0;
        end else begin
            pat_q   <= PATTERN;
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
        end
    end

    for (genvar n = 0; n < 8; n++) begin : g_ch
        led_fade_channel u_ch (
            .clk    (clk),
            .rst_ni (NOTRESET),
            .req_i  (pat_q[n]),
            .tick_i (tick),
            .pwm_i  (pwm_q),
            .led_o  (led_vec[n])
        );
    end

    assign LED0 = led_vec[0];
    assign LED1 = led_vec[1];
    assign LED2 = led_vec[2];
    assign LED3 = led_vec[3];
    assign LED4 = led_vec[4];
    assign LED5 = led_vec[5];
    assign LED6 = led_vec[6];
    assign LED7 = led_vec[7];

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: cycle scoreboard plus directed duty counts.
// Main instance uses DECAY_DIV=4, a second uses DECAY_DIV=64.
module tb_led_fade_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] pat;
    logic       nrst_d;
    logic [7:0] pat_d;
    logic       l7, l6, l5, l4, l3, l2, l1, l0;
    logic       d7, d6, d5, d4, d3, d2, d1, d0;
    logic [7:0] leds;
    logic [7:0] leds_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_fade_driver #(.DECAY_DIV(DIV)) u_dut (
        .clk(clk), .NOTRESET(nrst), .PATTERN(pat),
        .LED7(l7), .LED6(l6), .LED5(l5), .LED4(l4),
        .LED3(l3), .LED2(l2), .LED1(l1), .LED0(l0)
    );

    led_fade_driver #(.DECAY_DIV(64)) u_duty (
        .clk(clk), .NOTRESET(nrst_d), .PATTERN(pat_d),
        .LED7(d7), .LED6(d6), .LED5(d5), .LED4(d4),
        .LED3(d3), .LED2(d2), .LED1(d1), .LED0(d0)
    );

    assign leds   = {l7, l6, l5, l4, l3, l2, l1, l0};
    assign leds_d = {d7, d6, d5, d4, d3, d2, d1, d0};

    // Reference behaviour for the main instance, one entry per edge.
    logic [7:0] exp_q[$];
    bit         m_known = 1'b0;
    logic [7:0] m_pat;
    int         m_lvl[8];
    int         m_pre;
    int         m_pwm;
    logic [7:0] m_led;

    always @(posedge clk) begin
        bit ticked;
        if (!nrst) begin
            m_known = 1'b1;
            m_pat   = '0;
            m_pre   = 0;
            m_pwm   = 0;
            m_led   = '0;
            for (int n = 0; n < 8; n++) m_lvl[n] = 0;
        end else if (m_known) begin
            for (int n = 0; n < 8; n++) m_led[n] = (m_lvl[n] > m_pwm);
            ticked = (m_pre == DIV - 1);
            for (int n = 0; n < 8; n++) begin
                if (m_pat[n]) m_lvl[n] = 15;
                else if (ticked && m_lvl[n] > 0) m_lvl[n] = m_lvl[n] - 1;
            end
            m_pre = ticked ? 0 : m_pre + 1;
            m_pwm = (m_pwm == 14) ? 0 : m_pwm + 1;
            m_pat = pat;
        end
        if (m_known) exp_q.push_back(m_led);
    end

    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (leds !== e) begin
                errors++;
                $display("FAIL led_vec t=%0t got %b exp %b", $time, leds, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hi0;
        int hi_other;
        int hi2;
        int w15, w14, w8, other_d;

        nrst   = 1'b0;
        pat    = 8'hFF;
        nrst_d = 1'b0;
        pat_d  = 8'h00;

        // Reset held with all requests active.
        cyc(3);
        chk("reset_leds", 32'(leds), 32'h00);
        nrst = 1'b1;
        cyc(1);
        chk("rel_edge1", 32'(leds), 32'h00);
        cyc(1);
        chk("rel_edge2", 32'(leds), 32'h00);
        cyc(1);
        chk("rel_edge3", 32'(leds), 32'hFF);

        // Let every LED decay to dark.
        pat = 8'h00;
        cyc(80);
        chk("all_dark", 32'(leds), 32'h00);

        // Single-cycle request on LED0 then fade.
        pat = 8'h01;
        cyc(1);
        pat = 8'h00;
        hi0 = 0;
        hi_other = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1);
            if (l0) hi0++;
            if (leds[7:1] != 7'h00) hi_other++;
        end
        chk("fade_led0_lit", 32'(hi0 > 0), 32'd1);
        chk("fade_others_dark", 32'(hi_other), 32'd0);

        // Floor: more than ten ticks at level 0.
        hi0 = 0;
        for (int i = 0; i < 44; i++) begin
            cyc(1);
            if (leds != 8'h00) hi0++;
        end
        chk("floor_dark", 32'(hi0), 32'd0);

        // Request held across many ticks: never decremented.
        pat = 8'h04;
        cyc(2);
        hi2 = 0;
        for (int i = 0; i < 58; i++) begin
            cyc(1);
            if (l2) hi2++;
        end
        chk("collision_full", 32'(hi2), 32'd58);

        // Fade LED2 partway, then a one-cycle reset.
        pat = 8'h00;
        cyc(26);
        nrst = 1'b0;
        cyc(1);
        chk("midfade_reset", 32'(leds), 32'h00);
        nrst = 1'b1;
        pat = 8'h80;
        cyc(1);
        pat = 8'h00;
        cyc(3);
        chk("post_reset_led7", 32'(l7), 32'd1);
        cyc(70);
        chk("post_reset_dark", 32'(leds), 32'h00);

        // Duty windows on the DECAY_DIV=64 instance, LED3.
        cyc(1);
        nrst_d = 1'b1;
        pat_d  = 8'h08;
        w15 = 0;
        w14 = 0;
        w8 = 0;
        other_d = 0;
        for (int j = 1; j <= 474; j++) begin
            cyc(1);
            if (j == 1) pat_d = 8'h00;
            if (j >= 10 && j <= 24 && d3) w15++;
            if (j >= 70 && j <= 84 && d3) w14++;
            if (j >= 460 && j <= 474 && d3) w8++;
            if ((leds_d & 8'hF7) != 8'h00) other_d++;
        end
        chk("duty_l15", 32'(w15), 32'd15);
        chk("duty_l14", 32'(w14), 32'd14);
        chk("duty_l8", 32'(w8), 32'd8);
        chk("duty_others", 32'(other_d), 32'd0);

        cyc(2);
        chk("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
